// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch controller wrapped around the program
//               counter storage register. Per instruction it reads the PC,
//               requests the instruction word from memory, hands it
//               downstream over a valid/ready handshake and writes back the
//               next PC (PC+STEP or a branch redirect target).
// Ports       : CLK/RST           - clock, synchronous active-high reset
//               RUN               - keep fetching while high
//               PC_*              - read/write strobes, select and data of
//                                   the external PC register
//               IMEM_*            - instruction-memory request/ack/data
//               REDIRECT_*        - branch/jump redirect strobe and target
//               INSTR_*           - downstream instruction handshake
//               BUSY              - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int WIDTH         = 16,
   parameter int INSTR_WIDTH   = 16,
   parameter int STEP          = 1,
   parameter int PC_ADDR_WIDTH = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     RUN,
   output logic                     PC_READ_ENABLE,
   output logic                     PC_WRITE_ENABLE,
   output logic [PC_ADDR_WIDTH-1:0] PC_ADDRESS,
   output logic [WIDTH-1:0]         PC_DATA_IN,
   input  logic [WIDTH-1:0]         PC_DATA_OUT,
   output logic                     IMEM_REQ,
   output logic [WIDTH-1:0]         IMEM_ADDR,
   input  logic                     IMEM_ACK,
   input  logic [INSTR_WIDTH-1:0]   IMEM_DATA,
   input  logic                     REDIRECT_VALID,
   input  logic [WIDTH-1:0]         REDIRECT_TARGET,
   output logic                     INSTR_VALID,
   input  logic                     INSTR_READY,
   output logic [INSTR_WIDTH-1:0]   INSTR_OUT,
   output logic [WIDTH-1:0]         INSTR_PC,
   output logic                     BUSY
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_REQUEST = 3'd2;
   localparam logic [2:0] S_DELIVER = 3'd3;
   localparam logic [2:0] S_UPDATE  = 3'd4;

   localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

   logic [2:0]             state_q, state_d;
   logic [WIDTH-1:0]       fetch_pc_q, fetch_pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   redirect_pending_q, redirect_pending_d;
   logic [WIDTH-1:0]       redirect_target_q, redirect_target_d;
   logic [WIDTH-1:0]       w_next_pc;

   // A live redirect in the UPDATE cycle beats one captured earlier; the
   // sequential increment wraps silently at 2^WIDTH.
   assign w_next_pc = REDIRECT_VALID     ? REDIRECT_TARGET   :
                      redirect_pending_q ? redirect_target_q :
                                           fetch_pc_q + C_STEP;

   always_comb begin
      state_d            = state_q;
      fetch_pc_d         = fetch_pc_q;
      instr_d            = instr_q;
      redirect_pending_d = redirect_pending_q;
      redirect_target_d  = redirect_target_q;

      // Redirects are remembered in every active state; the latest one wins.
      if (state_q != S_IDLE && REDIRECT_VALID) begin
         redirect_pending_d = 1'b1;
         redirect_target_d  = REDIRECT_TARGET;
      end

      case (state_q)
         S_IDLE: begin
            if (RUN) state_d = S_FETCH;
         end
         S_FETCH: begin
            fetch_pc_d = PC_DATA_OUT;
            state_d    = S_REQUEST;
         end
         S_REQUEST: begin
            if (IMEM_ACK) begin
               instr_d = IMEM_DATA;
               // Wrong-path instruction: skip delivery and go straight to
               // the PC write that applies the redirect.
               state_d = (redirect_pending_q || REDIRECT_VALID) ? S_UPDATE
                                                                : S_DELIVER;
            end
         end
         S_DELIVER: begin
            // READY completes the transfer; a redirect without READY squashes.
            if (INSTR_READY || REDIRECT_VALID) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            redirect_pending_d = 1'b0;
            state_d            = RUN ? S_FETCH : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q            <= S_IDLE;
         fetch_pc_q         <= '0;
         instr_q            <= '0;
         redirect_pending_q <= 1'b0;
         redirect_target_q  <= '0;
      end else begin
         state_q            <= state_d;
         fetch_pc_q         <= fetch_pc_d;
         instr_q            <= instr_d;
         redirect_pending_q <= redirect_pending_d;
         redirect_target_q  <= redirect_target_d;
      end
   end

   // Outputs are decoded from the state alone (except PC_DATA_IN, which
   // follows a live redirect); data buses read as zero outside their state.
   always_comb begin
      PC_READ_ENABLE  = (state_q == S_FETCH);
      PC_WRITE_ENABLE = (state_q == S_UPDATE);
      PC_ADDRESS      = '0;
      PC_DATA_IN      = (state_q == S_UPDATE) ? w_next_pc : '0;
      IMEM_REQ        = (state_q == S_REQUEST);
      IMEM_ADDR       = (state_q == S_REQUEST) ? fetch_pc_q : '0;
      INSTR_VALID     = (state_q == S_DELIVER);
      INSTR_OUT       = (state_q == S_DELIVER) ? instr_q : '0;
      INSTR_PC        = (state_q == S_DELIVER) ? fetch_pc_q : '0;
      BUSY            = (state_q != S_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. Models the PC
//               register and a variable-latency instruction memory, runs
//               directed scenarios and a randomized run checked against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        RST, RUN;
   logic        PC_READ_ENABLE, PC_WRITE_ENABLE;
   logic [0:0]  PC_ADDRESS;
   logic [15:0] PC_DATA_IN, PC_DATA_OUT;
   logic        IMEM_REQ;
   logic [15:0] IMEM_ADDR;
   logic        IMEM_ACK = 1'b0;
   logic [15:0] IMEM_DATA = 16'h0;
   logic        REDIRECT_VALID;
   logic [15:0] REDIRECT_TARGET;
   logic        INSTR_VALID, INSTR_READY;
   logic [15:0] INSTR_OUT, INSTR_PC;
   logic        BUSY;

   int vec = 0;
   int bad = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.WIDTH(16), .INSTR_WIDTH(16), .STEP(1), .PC_ADDR_WIDTH(1)) dut (
      .CLK(clk), .RST(RST), .RUN(RUN),
      .PC_READ_ENABLE(PC_READ_ENABLE), .PC_WRITE_ENABLE(PC_WRITE_ENABLE),
      .PC_ADDRESS(PC_ADDRESS), .PC_DATA_IN(PC_DATA_IN), .PC_DATA_OUT(PC_DATA_OUT),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
      .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_TARGET(REDIRECT_TARGET),
      .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .INSTR_OUT(INSTR_OUT), .INSTR_PC(INSTR_PC), .BUSY(BUSY)
   );

   // PC register model with a bench-side preload port.
   logic [15:0] pc_reg = 16'h0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_load_val = 16'h0;
   always @(posedge clk) begin
      if (pc_load)              pc_reg <= pc_load_val;
      else if (PC_WRITE_ENABLE) pc_reg <= PC_DATA_IN;
   end
   assign PC_DATA_OUT = pc_reg;

   function automatic logic [15:0] instr_of(input logic [15:0] a);
      return (a * 16'd3) ^ 16'hC35A;
   endfunction

   // Instruction memory: fixed or random wait states, optional stray acks.
   int mem_wait = 0;
   int cur_wait = 0;
   int wait_cnt = 0;
   bit mem_rand = 1'b0;
   bit ack_force = 1'b0;
   always @(posedge clk) begin
      #1;
      if (IMEM_REQ === 1'b1) begin
         if (wait_cnt >= cur_wait) begin
            IMEM_ACK  = 1'b1;
            IMEM_DATA = instr_of(IMEM_ADDR);
            wait_cnt  = 0;
         end else begin
            IMEM_ACK  = 1'b0;
            IMEM_DATA = 16'h0BAD;
            wait_cnt++;
         end
      end else begin
         wait_cnt  = 0;
         cur_wait  = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
         IMEM_ACK  = ack_force || (mem_rand && $urandom_range(0, 3) == 0);
         IMEM_DATA = 16'hBEEF;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] v);
      pc_load_val = v;
      pc_load     = 1'b1;
      tick();
      pc_load     = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      RUN = 1'b0;
      INSTR_READY = 1'b1;
      REDIRECT_VALID = 1'b0;
      do begin
         tick();
         #1;
         n++;
      end while (BUSY && n < 40);
      vec++;
      if (BUSY !== 1'b0) begin
         bad++;
         $display("FAIL idle_timeout busy=%b required 0", BUSY);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; RUN = 1'b0; INSTR_READY = 1'b0;
      REDIRECT_VALID = 1'b0; REDIRECT_TARGET = 16'h0;
      pc_load_val = 16'h0; pc_load = 1'b1;
      repeat (3) tick();
      pc_load = 1'b0;
      RST = 1'b0;
      #1;
      vec++;
      if ({PC_READ_ENABLE, PC_WRITE_ENABLE, IMEM_REQ, INSTR_VALID, BUSY} !== 5'b0) begin
         bad++;
         $display("FAIL reset_strobes got %b required 00000",
                  {PC_READ_ENABLE, PC_WRITE_ENABLE, IMEM_REQ, INSTR_VALID, BUSY});
      end
      vec++;
      if ({PC_ADDRESS, PC_DATA_IN, IMEM_ADDR, INSTR_OUT, INSTR_PC} !== 65'b0) begin
         bad++;
         $display("FAIL reset_data got %h required 0",
                  {PC_ADDRESS, PC_DATA_IN, IMEM_ADDR, INSTR_OUT, INSTR_PC});
      end
      tick();
      #1;
      vec++;
      if (BUSY !== 1'b0) begin
         bad++;
         $display("FAIL idle_without_run busy=%b required 0", BUSY);
      end
   endtask

   task automatic test_sequential();
      logic [15:0] dpc[3], dout[3], wr[3];
      int dcyc[3];
      int nd, nw, cyc;
      nd = 0; nw = 0; cyc = 0;
      for (int i = 0; i < 3; i++) begin
         dpc[i] = 16'hFFFF; dout[i] = 16'hFFFF; wr[i] = 16'hFFFF; dcyc[i] = 0;
      end
      preload(16'h0000);
      mem_wait = 0; INSTR_READY = 1'b1; RUN = 1'b1;
      while (nw < 3 && cyc < 60) begin
         tick();
         #1;
         cyc++;
         if (INSTR_VALID && INSTR_READY && nd < 3) begin
            dpc[nd] = INSTR_PC; dout[nd] = INSTR_OUT; dcyc[nd] = cyc; nd++;
         end
         if (PC_WRITE_ENABLE) begin
            wr[nw] = PC_DATA_IN; nw++;
         end
      end
      wait_idle();
      vec++;
      if (nd != 3 || nw != 3) begin
         bad++;
         $display("FAIL seq_counts got %0d/%0d required 3/3", nd, nw);
      end
      for (int i = 0; i < 3; i++) begin
         vec++;
         if ({dpc[i], dout[i], wr[i]} !== {16'(i), instr_of(16'(i)), 16'(i + 1)}) begin
            bad++;
            $display("FAIL seq_instr%0d got pc=%h instr=%h wr=%h required pc=%h instr=%h wr=%h",
                     i, dpc[i], dout[i], wr[i], 16'(i), instr_of(16'(i)), 16'(i + 1));
         end
      end
      for (int i = 1; i < 3; i++) begin
         vec++;
         if (dcyc[i] - dcyc[i-1] != 4) begin
            bad++;
            $display("FAIL seq_spacing%0d got %0d required 4", i, dcyc[i] - dcyc[i-1]);
         end
      end
   endtask

   task automatic test_stall();
      int reqc, vc, xf, cyc;
      bit wrote;
      logic [15:0] wrv;
      reqc = 0; vc = 0; xf = 0; cyc = 0; wrote = 1'b0; wrv = 16'h0;
      mem_wait = 3;
      preload(16'h0040);
      RUN = 1'b1; INSTR_READY = 1'b0;
      while (!wrote && cyc < 60) begin
         tick();
         INSTR_READY = INSTR_VALID && (vc >= 2);
         #1;
         cyc++;
         if (IMEM_REQ) begin
            reqc++;
            vec++;
            if (IMEM_ADDR !== 16'h0040) begin
               bad++;
               $display("FAIL stall_addr got %h required 0040", IMEM_ADDR);
            end
         end
         if (INSTR_VALID) begin
            vc++;
            vec++;
            if ({INSTR_PC, INSTR_OUT} !== {16'h0040, instr_of(16'h0040)}) begin
               bad++;
               $display("FAIL stall_instr got %h/%h required 0040/%h",
                        INSTR_PC, INSTR_OUT, instr_of(16'h0040));
            end
            if (INSTR_READY) xf++;
         end
         if (PC_WRITE_ENABLE) begin
            wrote = 1'b1; wrv = PC_DATA_IN; RUN = 1'b0;
         end
      end
      wait_idle();
      mem_wait = 0;
      vec++;
      if (reqc != 4 || vc != 3 || xf != 1) begin
         bad++;
         $display("FAIL stall_counts got req=%0d valid=%0d xfer=%0d required 4/3/1", reqc, vc, xf);
      end
      vec++;
      if (!wrote || wrv !== 16'h0041) begin
         bad++;
         $display("FAIL stall_pcwrite got %h (wrote=%b) required 0041", wrv, wrote);
      end
   endtask

   task automatic test_redirect();
      bit fired, wrote, badel, seen_next;
      logic [15:0] wrv, nxt;
      int cyc;
      fired = 0; wrote = 0; badel = 0; seen_next = 0; wrv = 16'h0; nxt = 16'h0; cyc = 0;
      mem_wait = 2;
      preload(16'h0010);
      RUN = 1'b1; INSTR_READY = 1'b1;
      while (!seen_next && cyc < 60) begin
         tick();
         REDIRECT_VALID = 1'b0;
         if (IMEM_REQ && !fired) begin
            REDIRECT_VALID = 1'b1; REDIRECT_TARGET = 16'h0200; fired = 1'b1;
         end
         #1;
         cyc++;
         if (INSTR_VALID && !wrote) badel = 1'b1;
         if (PC_WRITE_ENABLE && !wrote) begin
            wrote = 1'b1; wrv = PC_DATA_IN;
         end else if (IMEM_REQ && wrote) begin
            seen_next = 1'b1; nxt = IMEM_ADDR;
         end
      end
      wait_idle();
      mem_wait = 0;
      vec++;
      if (badel !== 1'b0) begin
         bad++;
         $display("FAIL redirect_squash got delivered=%b required 0", badel);
      end
      vec++;
      if (wrv !== 16'h0200) begin
         bad++;
         $display("FAIL redirect_pcwrite got %h required 0200", wrv);
      end
      vec++;
      if (!seen_next || nxt !== 16'h0200) begin
         bad++;
         $display("FAIL redirect_nextaddr got %h (seen=%b) required 0200", nxt, seen_next);
      end
   endtask

   task automatic test_wrap();
      bit wrote, seen_next;
      logic [15:0] dpc, wrv, nxt;
      int cyc;
      wrote = 0; seen_next = 0; dpc = 16'h1234; wrv = 16'h1234; nxt = 16'h1234; cyc = 0;
      preload(16'hFFFF);
      RUN = 1'b1; INSTR_READY = 1'b1;
      while (!seen_next && cyc < 40) begin
         tick();
         #1;
         cyc++;
         if (INSTR_VALID && !wrote) dpc = INSTR_PC;
         if (PC_WRITE_ENABLE && !wrote) begin
            wrote = 1'b1; wrv = PC_DATA_IN;
         end else if (IMEM_REQ && wrote) begin
            seen_next = 1'b1; nxt = IMEM_ADDR;
         end
      end
      wait_idle();
      vec++;
      if ({dpc, wrv, nxt} !== {16'hFFFF, 16'h0000, 16'h0000}) begin
         bad++;
         $display("FAIL wrap got pc=%h wr=%h next=%h required FFFF/0000/0000", dpc, wrv, nxt);
      end
   endtask

   task automatic test_reset_midreq();
      int cyc, hits;
      cyc = 0; hits = 0;
      mem_wait = 10;
      preload(16'h0020);
      RUN = 1'b1;
      do begin
         tick();
         #1;
         cyc++;
      end while (!IMEM_REQ && cyc < 20);
      vec++;
      if (IMEM_REQ !== 1'b1) begin
         bad++;
         $display("FAIL midreq_reach got req=%b required 1", IMEM_REQ);
      end
      RST = 1'b1; RUN = 1'b0;
      tick();
      RST = 1'b0;
      #1;
      vec++;
      if ({IMEM_REQ, INSTR_VALID, BUSY} !== 3'b000) begin
         bad++;
         $display("FAIL midreq_reset got %b required 000", {IMEM_REQ, INSTR_VALID, BUSY});
      end
      ack_force = 1'b1;
      repeat (4) begin
         tick();
         #1;
         if (PC_WRITE_ENABLE || INSTR_VALID || BUSY || IMEM_REQ) hits++;
      end
      ack_force = 1'b0;
      mem_wait = 0;
      vec++;
      if (hits != 0 || pc_reg !== 16'h0020) begin
         bad++;
         $display("FAIL midreq_lateack got activity=%0d pc=%h required 0/0020", hits, pc_reg);
      end
   endtask

   task automatic test_run_drop();
      int xf, wc, rd_after;
      bit dropped;
      logic [15:0] wrv;
      xf = 0; wc = 0; rd_after = 0; dropped = 0; wrv = 16'h0;
      preload(16'h0030);
      RUN = 1'b1; INSTR_READY = 1'b0;
      repeat (14) begin
         tick();
         if (INSTR_VALID && !dropped) begin
            RUN = 1'b0; INSTR_READY = 1'b1; dropped = 1'b1;
         end
         #1;
         if (INSTR_VALID && INSTR_READY) xf++;
         if (PC_WRITE_ENABLE) begin
            wc++; wrv = PC_DATA_IN;
         end
         if (dropped && PC_READ_ENABLE) rd_after++;
      end
      vec++;
      if (xf != 1 || wc != 1 || wrv !== 16'h0031) begin
         bad++;
         $display("FAIL rundrop_finish got xfer=%0d writes=%0d wr=%h required 1/1/0031", xf, wc, wrv);
      end
      vec++;
      if (rd_after != 0 || BUSY !== 1'b0) begin
         bad++;
         $display("FAIL rundrop_idle got fetches=%0d busy=%b required 0/0", rd_after, BUSY);
      end
   endtask

   // Transaction-level reference: an instruction spans one PC write. It is
   // delivered once unless a redirect was seen earlier in its lifetime, and
   // its PC write is the latest redirect target (live one first) or pc+1.
   task automatic test_random();
      logic [15:0] exp_pc, redir_tgt, exp_wr;
      bit redir_seen, delivered;
      int ninst, cyc;
      exp_pc = 16'($urandom);
      redir_tgt = 16'h0; redir_seen = 0; delivered = 0; ninst = 0; cyc = 0;
      mem_rand = 1'b1;
      preload(exp_pc);
      RUN = 1'b1;
      while (ninst < 150 && cyc < 5000) begin
         tick();
         cyc++;
         INSTR_READY     = ($urandom_range(0, 1) == 1);
         REDIRECT_VALID  = BUSY && ($urandom_range(0, 7) == 0);
         REDIRECT_TARGET = 16'($urandom);
         #1;
         vec++;
         if (PC_READ_ENABLE && PC_WRITE_ENABLE) begin
            bad++;
            $display("FAIL rnd_rw_exclusive got rd=1 wr=1 required not both");
         end
         if (IMEM_REQ) begin
            vec++;
            if (IMEM_ADDR !== exp_pc) begin
               bad++;
               $display("FAIL rnd_imem_addr got %h required %h", IMEM_ADDR, exp_pc);
            end
         end
         if (INSTR_VALID) begin
            vec++;
            if ({redir_seen, delivered, INSTR_PC, INSTR_OUT} !==
                {1'b0, 1'b0, exp_pc, instr_of(exp_pc)}) begin
               bad++;
               $display("FAIL rnd_deliver got pc=%h instr=%h (squashed=%b dup=%b) required pc=%h instr=%h",
                        INSTR_PC, INSTR_OUT, redir_seen, delivered, exp_pc, instr_of(exp_pc));
            end
            if (INSTR_READY) delivered = 1'b1;
         end
         if (PC_WRITE_ENABLE) begin
            exp_wr = REDIRECT_VALID ? REDIRECT_TARGET : redir_seen ? redir_tgt : exp_pc + 16'd1;
            vec++;
            if (PC_DATA_IN !== exp_wr || !(delivered || redir_seen)) begin
               bad++;
               $display("FAIL rnd_pcwrite got %h (delivered=%b) required %h",
                        PC_DATA_IN, delivered, exp_wr);
            end
            exp_pc = exp_wr;
            redir_seen = 1'b0;
            delivered = 1'b0;
            ninst++;
         end else if (REDIRECT_VALID) begin
            redir_seen = 1'b1;
            redir_tgt  = REDIRECT_TARGET;
         end
      end
      vec++;
      if (ninst < 150) begin
         bad++;
         $display("FAIL rnd_progress got %0d instructions required 150", ninst);
      end
      wait_idle();
      mem_rand = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1);
   end

   initial begin
      RST = 1'b1; RUN = 1'b0; INSTR_READY = 1'b0;
      REDIRECT_VALID = 1'b0; REDIRECT_TARGET = 16'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_wrap();
      test_reset_midreq();
      test_run_drop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
`default_nettype wire
